// File: rtl/gstdmasnd_pkg.sv
// gstdmasnd_pkg -- shared constants for the sound DMA playback block.
//   RATE_*        : encodings of mode[1:0] (sample rate select)
//   SILENCE       : unsigned mid-scale sample value
//   MODE_*        : bit positions inside the 3-bit mode word
//   rate_hit()    : decides whether a base tick is also a sample strobe
package gstdmasnd_pkg;

    localparam logic [1:0] RATE_6K25 = 2'b00;
    localparam logic [1:0] RATE_12K5 = 2'b01;
    localparam logic [1:0] RATE_25K  = 2'b10;
    localparam logic [1:0] RATE_50K  = 2'b11;

    localparam logic [7:0] SILENCE = 8'h80;

    localparam int MODE_MONO_BIT = 2;
    localparam int MODE_RATE_MSB = 1;
    localparam int MODE_RATE_LSB = 0;

    // aclk is the divider value before its increment on this base tick.
    function automatic logic rate_hit(input logic [1:0] rate, input logic [2:0] aclk);
        case (rate)
            RATE_50K:  return 1'b1;
            RATE_25K:  return ~aclk[0];
            RATE_12K5: return (aclk[1:0] == 2'b00);
            default:   return (aclk == 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/gstdmasnd_if.sv
// gstdmasnd_if -- sound DMA bus between the bus controller and gstdmasnd.
//   SLOAD_N : word load strobe, active-low (controller -> sound block)
//   MDIN    : 16-bit RAM data word        (controller -> sound block)
//   SREQ    : DMA request                 (sound block -> controller)
interface gstdmasnd_if;
    logic        SLOAD_N;
    logic [15:0] MDIN;
    logic        SREQ;

    modport master (output SLOAD_N, output MDIN, input SREQ);
    modport slave  (input SLOAD_N, input MDIN, output SREQ);
endinterface

// File: rtl/gstdmasnd_fifo.sv
// gstdmasnd_fifo -- synchronous FIFO of 2**ADDR_BITS 16-bit words.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   flush      : synchronous pointer clear
//   push/wdata : write request and data; ignored when full
//   pop/rdata  : read request; rdata shows the head word (valid when !empty)
//   full/empty : status
//   level      : occupancy 0..DEPTH
// Pointers carry one extra wrap bit so every storage slot is usable.
module gstdmasnd_fifo #(
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 push,
    input  logic                 pop,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   level
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [15:0]        mem [DEPTH];
    logic [ADDR_BITS:0] wr_ptr;
    logic [ADDR_BITS:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                     (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[ADDR_BITS-1:0]];
    // A write at full is dropped even if a pop happens in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[ADDR_BITS-1:0]] <= wdata;
    end

endmodule

// File: rtl/gstdmasnd.sv
// gstdmasnd -- sound DMA playback: buffers 16-bit words from the bus and
// plays them as 8-bit unsigned stereo or mono samples at 6.25..50 kHz.
//   clk32, resb        : 32 MHz clock, asynchronous active-low reset
//   ena                : playback enable; low flushes FIFO and timing
//   mode[2:0]          : [2] mono, [1:0] rate select
//   clr_flags          : clears underrun/overflow (a same-cycle set wins)
//   bus (slave)        : SLOAD_N / MDIN in, SREQ out
//   audio_left/right   : unsigned 8-bit samples
//   level              : FIFO occupancy
//   underrun, overflow : sticky error flags
// Build option GSTDMASND_HOLD_EN: when defined, an empty strobe holds the
// last sample; otherwise the outputs fall back to silence.
module gstdmasnd
    import gstdmasnd_pkg::*;
#(
    parameter int FIFO_ADDR_BITS = 3,
    parameter int BASE_DIV       = 640,
    parameter int REQ_MARGIN     = 1
) (
    input  logic                      clk32,
    input  logic                      resb,
    input  logic                      ena,
    input  logic [2:0]                mode,
    input  logic                      clr_flags,
    gstdmasnd_if.slave                bus,
    output logic [7:0]                audio_left,
    output logic [7:0]                audio_right,
    output logic [FIFO_ADDR_BITS:0]   level,
    output logic                      underrun,
    output logic                      overflow
);
    localparam int DEPTH = 1 << FIFO_ADDR_BITS;
    localparam int BW    = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam logic [BW-1:0] BASE_LAST = BW'(BASE_DIV - 1);
    localparam logic [FIFO_ADDR_BITS:0] REQ_LIMIT =
        (FIFO_ADDR_BITS + 1)'(DEPTH - 1 - REQ_MARGIN);

    logic          sload_d;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [15:0]   fifo_rdata;
    logic [BW-1:0] base_cnt;
    logic [2:0]    aclk_cnt;
    logic          base_tick;
    logic          strobe;
    logic          mono;
    logic          bytesel;
    logic [7:0]    mono_byte;

    // Falling-edge detect on the load strobe.
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) sload_d <= 1'b1;
        else       sload_d <= bus.SLOAD_N;
    end

    assign push      = ena & sload_d & ~bus.SLOAD_N;
    assign mono      = mode[MODE_MONO_BIT];
    assign base_tick = (base_cnt == BASE_LAST);
    assign strobe    = ena & base_tick &
                       rate_hit(mode[MODE_RATE_MSB:MODE_RATE_LSB], aclk_cnt);
    // In mono a word carries two samples; it is popped after its low byte.
    assign pop       = strobe & ~fifo_empty & (~mono | bytesel);
    assign mono_byte = bytesel ? fifo_rdata[7:0] : fifo_rdata[15:8];
    assign bus.SREQ  = ena & (level <= REQ_LIMIT);

    gstdmasnd_fifo #(.ADDR_BITS(FIFO_ADDR_BITS)) u_fifo (
        .clk   (clk32),
        .rst_n (resb),
        .flush (~ena),
        .push  (push),
        .pop   (pop),
        .wdata (bus.MDIN),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            base_cnt <= '0;
            aclk_cnt <= '0;
        end else if (!ena) begin
            base_cnt <= '0;
            aclk_cnt <= '0;
        end else if (base_tick) begin
            base_cnt <= '0;
            aclk_cnt <= aclk_cnt + 3'd1;
        end else begin
            base_cnt <= base_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            audio_left  <= SILENCE;
            audio_right <= SILENCE;
            bytesel     <= 1'b0;
        end else if (!ena) begin
            audio_left  <= SILENCE;
            audio_right <= SILENCE;
            bytesel     <= 1'b0;
        end else if (strobe) begin
            if (!fifo_empty) begin
                if (mono) begin
                    audio_left  <= mono_byte ^ SILENCE;
                    audio_right <= mono_byte ^ SILENCE;
                    bytesel     <= ~bytesel;
                end else begin
                    audio_left  <= fifo_rdata[15:8] ^ SILENCE;
                    audio_right <= fifo_rdata[7:0] ^ SILENCE;
                end
            end else begin
`ifdef GSTDMASND_HOLD_EN
                audio_left  <= audio_left;
                audio_right <= audio_right;
`else
                audio_left  <= SILENCE;
                audio_right <= SILENCE;
`endif
            end
        end
    end

    // Flags ignore ena; only clr_flags clears them, and a new event beats it.
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            underrun <= (strobe & fifo_empty) | (underrun & ~clr_flags);
            overflow <= (push & fifo_full)    | (overflow & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_gstdmasnd.sv
module tb_gstdmasnd;
    logic       clk32 = 1'b0;
    logic       resb;
    logic       ena;
    logic [2:0] mode;
    logic       clr_flags;
    logic [7:0] audio_left;
    logic [7:0] audio_right;
    logic [3:0] level;
    logic       underrun;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    gstdmasnd_if bus_if ();

    gstdmasnd dut (
        .clk32       (clk32),
        .resb        (resb),
        .ena         (ena),
        .mode        (mode),
        .clr_flags   (clr_flags),
        .bus         (bus_if),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .level       (level),
        .underrun    (underrun),
        .overflow    (overflow)
    );

    always #5 clk32 = ~clk32;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] probe(input int sel);
        case (sel)
            0:       return {8'h00, audio_left};
            1:       return {12'h000, level};
            2:       return {15'h0000, underrun};
            default: return 16'h0000;
        endcase
    endfunction

    // Bounded wait for a signal to reach a value; timeout shows as a FAIL.
    task automatic wait_for(input int sel, input logic [15:0] exp, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk32);
            if (probe(sel) === exp) break;
        end
        check(tag, probe(sel), exp);
    endtask

    task automatic push_word(input logic [15:0] w);
        bus_if.SLOAD_N = 1'b0;
        bus_if.MDIN    = w;
        @(negedge clk32);
        bus_if.SLOAD_N = 1'b1;
        @(negedge clk32);
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        @(negedge clk32);
        clr_flags = 1'b0;
    endtask

    task automatic restart(input logic [2:0] m);
        ena  = 1'b0;
        mode = m;
        @(negedge clk32);
        ena = 1'b1;
    endtask

    logic [15:0] w;

    initial begin
        resb = 1'b0; ena = 1'b1; mode = 3'b011; clr_flags = 1'b0;
        bus_if.SLOAD_N = 1'b1; bus_if.MDIN = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk32);
        check("rst_sreq", {15'h0, bus_if.SREQ}, 16'h0001);
        check("rst_level", {12'h0, level}, 16'h0000);
        check("rst_left", {8'h0, audio_left}, 16'h0080);
        check("rst_right", {8'h0, audio_right}, 16'h0080);
        check("rst_underrun", {15'h0, underrun}, 16'h0000);
        check("rst_overflow", {15'h0, overflow}, 16'h0000);
        resb = 1'b1;
        @(negedge clk32);
        check("post_rst_sreq", {15'h0, bus_if.SREQ}, 16'h0001);
        check("post_rst_level", {12'h0, level}, 16'h0000);

        // Fill to DEPTH=8; SREQ high only while level <= 6
        for (int i = 0; i < 8; i++) begin
            w = 16'h1020 + 16'(i) * 16'h0101;
            push_word(w);
            check($sformatf("fill_level_%0d", i), {12'h0, level}, 16'(i + 1));
            check($sformatf("fill_sreq_%0d", i), {15'h0, bus_if.SREQ}, (i + 1 <= 6) ? 16'h0001 : 16'h0000);
        end
        push_word(16'hDEAD);
        check("ovf_level", {12'h0, level}, 16'h0008);
        check("ovf_flag", {15'h0, overflow}, 16'h0001);
        pulse_clr();
        check("ovf_clear", {15'h0, overflow}, 16'h0000);

        // Disable flushes and silences
        ena = 1'b0;
        @(negedge clk32);
        check("dis_level", {12'h0, level}, 16'h0000);
        check("dis_sreq", {15'h0, bus_if.SREQ}, 16'h0000);
        check("dis_left", {8'h0, audio_left}, 16'h0080);

        // Stereo at 50 kHz: 0x7F80 then 0x1234, then an empty strobe
        restart(3'b011);
        push_word(16'h7F80);
        push_word(16'h1234);
        check("st_level2", {12'h0, level}, 16'h0002);
        wait_for(0, 16'h00FF, 700, "st1_left");
        check("st1_right", {8'h0, audio_right}, 16'h0000);
        check("st1_level", {12'h0, level}, 16'h0001);
        wait_for(0, 16'h0092, 700, "st2_left");
        check("st2_right", {8'h0, audio_right}, 16'h00B4);
        check("st2_level", {12'h0, level}, 16'h0000);
        wait_for(2, 16'h0001, 700, "udr_flag");
`ifdef GSTDMASND_HOLD_EN
        check("udr_left", {8'h0, audio_left}, 16'h0092);
        check("udr_right", {8'h0, audio_right}, 16'h00B4);
`else
        check("udr_left", {8'h0, audio_left}, 16'h0080);
        check("udr_right", {8'h0, audio_right}, 16'h0080);
`endif
        check("udr_level", {12'h0, level}, 16'h0000);
        pulse_clr();
        check("udr_clear", {15'h0, underrun}, 16'h0000);

        // Mono at 6.25 kHz: 0x0102 -> 0x81 then 0x82, pop after the second
        restart(3'b100);
        push_word(16'h0102);
        wait_for(0, 16'h0081, 700, "mono1_left");
        check("mono1_right", {8'h0, audio_right}, 16'h0081);
        check("mono1_level", {12'h0, level}, 16'h0001);
        repeat (5000) @(negedge clk32);
        check("mono_hold", {8'h0, audio_left}, 16'h0081);
        wait_for(0, 16'h0082, 300, "mono2_left");
        check("mono2_right", {8'h0, audio_right}, 16'h0082);
        check("mono2_level", {12'h0, level}, 16'h0000);

        // Push coincident with pop at level 3
        restart(3'b011);
        push_word(16'hAABB);
        push_word(16'hCCDD);
        push_word(16'hEEFF);
        push_word(16'h5566);
        wait_for(1, 16'h0003, 700, "co_first_pop");
        check("co_first_left", {8'h0, audio_left}, 16'h002A);
        repeat (639) @(negedge clk32);
        bus_if.SLOAD_N = 1'b0;
        bus_if.MDIN    = 16'h7788;
        @(negedge clk32);
        bus_if.SLOAD_N = 1'b1;
        check("co_level", {12'h0, level}, 16'h0003);
        check("co_left", {8'h0, audio_left}, 16'h004C);
        check("co_right", {8'h0, audio_right}, 16'h005D);
        check("co_overflow", {15'h0, overflow}, 16'h0000);

        // Asynchronous reset mid-stream
        #2;
        resb = 1'b0;
        #1;
        check("arst_level", {12'h0, level}, 16'h0000);
        check("arst_left", {8'h0, audio_left}, 16'h0080);
        check("arst_right", {8'h0, audio_right}, 16'h0080);
        @(negedge clk32);
        resb = 1'b1;
        @(negedge clk32);
        check("arst_sreq", {15'h0, bus_if.SREQ}, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gstdmasnd.md
GSTDMASND -- requirements
Module: gstdmasnd

Interface
REQ-001 Parameter FIFO_ADDR_BITS, default 3, sets FIFO depth DEPTH = 2**FIFO_ADDR_BITS 16-bit words; legal range 2..6.
REQ-002 Parameter BASE_DIV, default 640, sets clk32 cycles per base tick (32 MHz/640 = 50 kHz).
REQ-003 Parameter REQ_MARGIN, default 1, sets free words kept in reserve before SREQ drops; legal range 0..DEPTH-1.
REQ-004 clk32  in  1  system clock; all logic is on its rising edge.
REQ-005 resb  in  1  reset, asynchronous assert, active-low.
REQ-006 ena  in  1  playback enable; low flushes the block.
REQ-007 mode  in  3  [2] = mono, [1:0] = rate: 00 = 6.25, 01 = 12.5, 10 = 25, 11 = 50 kHz.
REQ-008 SLOAD_N  in  1  sound-word load strobe from the bus controller, active-low.
REQ-009 MDIN  in  16  RAM data, sampled on the SLOAD_N falling edge.
REQ-010 clr_flags  in  1  clears the sticky flags.
REQ-011 SREQ  out  1  sound DMA request.
REQ-012 audio_left, audio_right  out  8 each  unsigned samples.
REQ-013 level  out  FIFO_ADDR_BITS+1  FIFO occupancy, 0..DEPTH.
REQ-014 underrun, overflow  out  1 each  sticky error flags.

Function
REQ-015 Push: sload_d registers SLOAD_N; a push occurs in the cycle where sload_d=1 and SLOAD_N=0.
REQ-016 Push is accepted only if level<DEPTH at that cycle; at level=DEPTH the word is dropped and overflow is set.
REQ-017 All DEPTH words are usable; full/empty use pointers one bit wider than the address.
REQ-018 SREQ = ena AND (level <= DEPTH-1-REQ_MARGIN), combinational from registered state.
REQ-019 Base counter runs 0..BASE_DIV-1 and wraps; base tick fires at count BASE_DIV-1.
REQ-020 A 3-bit aclk_cnt increments on each base tick.
REQ-021 Sample strobe fires on a base tick, with aclk_cnt taken before its increment, when:
- rate 11: always
- rate 10: aclk_cnt[0]=0
- rate 01: aclk_cnt[1:0]=0
- rate 00: aclk_cnt=0
REQ-022 Stereo strobe, FIFO non-empty: audio_left = word[15:8]^8'h80, audio_right = word[7:0]^8'h80; pop.
REQ-023 Mono strobe, FIFO non-empty: byte = bytesel ? word[7:0] : word[15:8]; both channels = byte^8'h80; toggle bytesel; pop only when bytesel was 1.
REQ-024 Outputs update on the clock edge that ends the strobe cycle (1-cycle latency).
REQ-025 Strobe with FIFO empty: underrun is set and no pop occurs; output behaviour is per REQ-033.
REQ-026 Simultaneous push and pop: both take effect and level is unchanged; a push at level=DEPTH with a same-cycle pop is still dropped.
REQ-027 Flags: clr_flags clears them; a same-cycle set wins over clear.
REQ-028 A mode change takes effect at the next strobe; bytesel is not altered by a mode change.
REQ-029 ena=0 (synchronous):
- pointers, bytesel, base counter and aclk_cnt cleared
- audio outputs = 8'h80
- pushes ignored
- flags held

Reset
REQ-030 resb=0 asynchronously forces:
- pointers, level, bytesel, base counter and aclk_cnt to 0
- sload_d to 1
- audio outputs to 8'h80
- underrun and overflow to 0
REQ-031 SREQ during reset equals ena.
REQ-032 FIFO storage is not reset; reset mid-transfer discards all buffered words.

Configuration
REQ-033 Macro GSTDMASND_HOLD_EN selects underrun output behaviour:
- defined: outputs hold the last sample on an empty strobe
- undefined: outputs go to 8'h80 on an empty strobe
The flag behaviour is identical in both cases.

Structure
REQ-034 Package gstdmasnd_pkg holds:
- rate encoding constants RATE_6K25, RATE_12K5, RATE_25K, RATE_50K
- SILENCE = 8'h80
- the mode bit-position constants
REQ-035 Sub-module gstdmasnd_fifo: parametrised synchronous FIFO with push, pop, full, empty and level; storage plus pointers only.

Verification
REQ-036 Reset, ena=1, default parameters -> SREQ=1, level=0, audio_left = audio_right = 8'h80, flags 0.
REQ-037 Push 8 words (0x1020, ...) with no strobes -> level=8, SREQ drops once level>=7; 9th push is dropped and overflow=1.
REQ-038 mode=011, FIFO holds 0x7F80 -> after the first strobe (within 640 cycles) audio_left=8'hFF, audio_right=8'h00, level decrements by 1.
REQ-039 mode=100, FIFO holds 0x0102 -> two strobes 5120 cycles apart output 8'h81 then 8'h82 on both channels; pop occurs only after the second strobe.
REQ-040 Empty FIFO at strobe -> underrun=1; output holds the last sample with GSTDMASND_HOLD_EN defined, 8'h80 without; clr_flags then clears underrun.
REQ-041 Push coincident with pop at level=3 -> level stays 3; resb pulsed mid-stream -> immediate level=0 and outputs 8'h80.
